// File: rtl/dmem_timer.sv
// Word-addressed data RAM with a memory-mapped countdown timer and interrupt.
// Define DMEM_TIMER_EN to build the timer; otherwise its addresses read 0 and irq is 0.
module dmem_timer #(
    parameter int          AW       = 10,
    parameter logic [31:0] TMR_BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_data,
    input  logic        dmem_we,
    output logic [31:0] dmem_out,
    output logic        irq
);

    logic [31:0]   mem [2**AW];
    logic          ram_hit;
    logic [AW-1:0] widx;

    assign ram_hit = (dmem_addr[31:AW+2] == '0);
    assign widx    = dmem_addr[AW+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        end else if (dmem_we && ram_hit) begin
            mem[widx] <= dmem_data;
        end
    end

`ifdef DMEM_TIMER_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] count, count_nxt;
    logic [31:0] preset;
    logic        ctrl_en, ctrl_mode, ctrl_im;
    logic        pending;
    logic        irq_q;
    logic        en_clr, int_set;
    logic        tmr_hit, ctrl_wr, preset_wr;
    logic        unused;

    assign tmr_hit   = (dmem_addr[31:4] == TMR_BASE[31:4]) && (dmem_addr[3:2] != 2'd3);
    assign ctrl_wr   = dmem_we && tmr_hit && (dmem_addr[3:2] == 2'd0);
    assign preset_wr = dmem_we && tmr_hit && (dmem_addr[3:2] == 2'd1);
    assign unused    = ^{dmem_addr[1:0], TMR_BASE[3:0]};

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        en_clr    = 1'b0;
        int_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl_en) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                count_nxt = preset;
                state_nxt = (preset == 32'd0) ? S_INT : S_CNT;
            end
            S_CNT: begin
                // Disabling mid-count parks in IDLE with COUNT frozen.
                if (!ctrl_en) begin
                    state_nxt = S_IDLE;
                end else if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    count_nxt = 32'd0;
                    state_nxt = S_INT;
                end
            end
            S_INT: begin
                int_set = 1'b1;
                if (ctrl_mode) begin
                    state_nxt = S_LOAD;
                end else begin
                    en_clr    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            preset    <= '0;
            ctrl_en   <= 1'b0;
            ctrl_mode <= 1'b0;
            ctrl_im   <= 1'b0;
            pending   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            // CPU writes to CTRL take priority over the FSM's one-shot clear.
            if (ctrl_wr) begin
                ctrl_en   <= dmem_data[0];
                ctrl_mode <= dmem_data[1];
                ctrl_im   <= dmem_data[3];
            end else if (en_clr) begin
                ctrl_en <= 1'b0;
            end
            if (preset_wr) preset <= dmem_data;
            if (ctrl_wr) pending <= 1'b0;
            else if (int_set) pending <= 1'b1;
            irq_q <= pending & ctrl_im;
        end
    end

    always_comb begin
        dmem_out = '0;
        if (ram_hit) begin
            dmem_out = mem[widx];
        end else if (tmr_hit) begin
            case (dmem_addr[3:2])
                2'd0:    dmem_out = {28'd0, ctrl_im, 1'b0, ctrl_mode, ctrl_en};
                2'd1:    dmem_out = preset;
                2'd2:    dmem_out = count;
                default: dmem_out = '0;
            endcase
        end
    end

    assign irq = irq_q;
`else
    logic unused;

    assign unused   = ^{dmem_addr[1:0], TMR_BASE, clk};
    assign dmem_out = ram_hit ? mem[widx] : 32'd0;
    assign irq      = 1'b0;
`endif

endmodule
